// File: rtl/coherence_bus_ctrl.sv
// Bus-side MESI coherence controller: arbitrates two snooping data caches and an
// instruction-fetch port onto a single-ported RAM (ramstate: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
module coherence_bus_ctrl #(
    parameter int unsigned CPUS     = 2,
    parameter int unsigned BLKWORDS = 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [CPUS-1:0]           dREN,
    input  logic [CPUS-1:0]           dWEN,
    input  logic [CPUS-1:0][31:0]     daddr,
    input  logic [CPUS-1:0][31:0]     dstore,
    input  logic [CPUS-1:0]           ccwrite,
    input  logic [CPUS-1:0]           cctrans,
    output logic [CPUS-1:0]           dwait,
    output logic [CPUS-1:0][31:0]     dload,
    output logic [CPUS-1:0]           ccwait,
    output logic [CPUS-1:0]           ccinv,
    output logic [CPUS-1:0][31:0]     ccsnoopaddr,
    input  logic                      iREN,
    input  logic [31:0]               iaddr,
    output logic                      iwait,
    output logic [31:0]               iload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  logic [1:0]                ramstate
);

    localparam logic [1:0] RamAccess = 2'd2;

    typedef enum logic [2:0] {
        StIdle, StIfetch, StWb, StSnoop, StRamRd, StC2c, StInv
    } state_e;

    state_e r_state, w_state_d;
    logic   r_req, w_req_d;
    logic   r_rr, w_rr_d;
    logic   r_wcnt, w_wcnt_d;
    logic   r_scnt, w_scnt_d;
    logic   r_hit, w_hit_d;

    logic            w_s;
    logic            w_access;
    logic            w_last;
    logic            w_inv;
    logic            w_take;
    logic [CPUS-1:0] w_coh;

    assign w_s      = ~r_req;
    assign w_access = (ramstate == RamAccess);
    assign w_last   = (r_wcnt == 1'(BLKWORDS - 1));
    assign w_inv    = ccwrite[r_req] & ~dREN[r_req];
    // A write hit to a SHARED line is coherent too; it only needs an invalidate.
    assign w_coh    = dREN | ccwrite;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_rr    <= 1'b1;
            r_wcnt  <= 1'b0;
            r_scnt  <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_rr    <= w_rr_d;
            r_wcnt  <= w_wcnt_d;
            r_scnt  <= w_scnt_d;
            r_hit   <= w_hit_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_req_d     = r_req;
        w_rr_d      = r_rr;
        w_wcnt_d    = r_wcnt;
        w_scnt_d    = r_scnt;
        w_hit_d     = r_hit;
        w_take      = 1'b0;
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        iwait       = 1'b1;
        iload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        unique case (r_state)
            StIdle: begin
                w_wcnt_d = 1'b0;
                w_scnt_d = 1'b0;
                w_hit_d  = 1'b0;
                if (w_coh[~r_rr]) begin
                    w_req_d   = ~r_rr;
                    w_state_d = StSnoop;
                end else if (w_coh[r_rr]) begin
                    w_req_d   = r_rr;
                    w_state_d = StSnoop;
                end else if (dWEN[0] && !dREN[0]) begin
                    w_req_d   = 1'b0;
                    w_state_d = StWb;
                end else if (dWEN[1] && !dREN[1]) begin
                    w_req_d   = 1'b1;
                    w_state_d = StWb;
                end else if (iREN) begin
                    w_state_d = StIfetch;
                end
            end
            StIfetch: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (w_access) begin
                    iwait     = 1'b0;
                    iload     = ramload;
                    w_state_d = StIdle;
                end
            end
            StWb: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r_req];
                ramstore = dstore[r_req];
                if (w_access) begin
                    dwait[r_req] = 1'b0;
                    w_state_d    = StIdle;
                end
            end
            StSnoop: begin
                ccwait[w_s]      = 1'b1;
                ccinv[w_s]       = w_inv;
                ccsnoopaddr[w_s] = daddr[r_req];
                if (!r_scnt) begin
                    w_scnt_d = 1'b1;
                end else begin
                    w_scnt_d = 1'b0;
                    w_hit_d  = dWEN[w_s];
                    if (w_inv) begin
                        w_state_d = StInv;
                    end else if (dWEN[w_s] || r_hit) begin
                        w_state_d = StC2c;
                    end else begin
                        w_state_d = StRamRd;
                    end
                end
            end
            StInv: begin
                ccwait[w_s]      = 1'b1;
                ccinv[w_s]       = 1'b1;
                ccsnoopaddr[w_s] = daddr[r_req];
                dwait[r_req]     = 1'b0;
                w_rr_d           = r_req;
                w_state_d        = StIdle;
            end
            StRamRd: begin
                ramREN  = 1'b1;
                ramaddr = daddr[r_req];
                if (w_access) begin
                    dload[r_req] = ramload;
                    w_take       = 1'b1;
                end
            end
            StC2c: begin
                ccwait[w_s]      = 1'b1;
                ccsnoopaddr[w_s] = daddr[r_req];
                dload[r_req]     = dstore[w_s];
                // A MODIFIED supplier's data goes to RAM too, so the word waits on RAM.
                if (cctrans[w_s]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[r_req];
                    ramstore = dstore[w_s];
                    w_take   = w_access;
                end else begin
                    w_take   = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_take) begin
            dwait[r_req] = 1'b0;
            if (w_last) begin
                w_wcnt_d  = 1'b0;
                w_rr_d    = r_req;
                w_state_d = StIdle;
            end else begin
                w_wcnt_d = r_wcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed self-checking bench for coherence_bus_ctrl: fetch, RAM fill,
// cache-to-cache fill with writeback, invalidate, round-robin and async reset.
module tb_coherence_bus_ctrl;

    localparam logic [1:0] RamFree   = 2'd0;
    localparam logic [1:0] RamBusy   = 2'd1;
    localparam logic [1:0] RamAccess = 2'd2;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       dREN, dWEN, ccwrite, cctrans;
    logic [1:0][31:0] daddr, dstore;
    logic [1:0]       dwait, ccwait, ccinv;
    logic [1:0][31:0] dload, ccsnoopaddr;
    logic             iREN, iwait, ramREN, ramWEN;
    logic [31:0]      iaddr, iload, ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.CPUS(2), .BLKWORDS(2)) u_dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .ccwrite     (ccwrite),
        .cctrans     (cctrans),
        .dwait       (dwait),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .iwait       (iwait),
        .iload       (iload),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " dwait"}, 32'(dwait), 32'h3);
        check({tag, " iwait"}, 32'(iwait), 32'h1);
        check({tag, " ccwait"}, 32'(ccwait), 32'h0);
        check({tag, " ccinv"}, 32'(ccinv), 32'h0);
        check({tag, " ramstrobes"}, 32'({ramREN, ramWEN}), 32'h0);
        check({tag, " ramaddr"}, ramaddr, 32'h0);
    endtask

    initial begin
        nRST = 1'b0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        daddr = '0; dstore = '0; iREN = 1'b0; iaddr = '0; ramload = '0;
        ramstate = RamFree;
        #2;
        check_idle_outputs("reset");
        tick(); tick();
        nRST = 1'b1;
        tick(); settle();
        check_idle_outputs("idle_after_reset");

        // Instruction fetch
        iREN = 1'b1; iaddr = 32'h40; ramstate = RamAccess; ramload = 32'hDEADBEEF;
        tick(); settle();
        check("ifetch iwait", 32'(iwait), 32'h0);
        check("ifetch iload", iload, 32'hDEADBEEF);
        check("ifetch ramaddr", ramaddr, 32'h40);
        check("ifetch ramREN", 32'(ramREN), 32'h1);
        check("ifetch dwait", 32'(dwait), 32'h3);
        iREN = 1'b0;
        tick(); settle();
        check_idle_outputs("ifetch_done");

        // Cache 0 fill from RAM, cache 1 misses the snoop
        dREN[0] = 1'b1; daddr[0] = 32'h100;
        tick(); settle();
        check("fill0 snoop1 ccwait", 32'(ccwait), 32'h2);
        check("fill0 snoop1 addr", ccsnoopaddr[1], 32'h100);
        check("fill0 snoop1 ccinv", 32'(ccinv), 32'h0);
        check("fill0 snoop1 ram", 32'({ramREN, ramWEN}), 32'h0);
        ramstate = RamBusy;
        tick(); settle();
        check("fill0 snoop2 ccwait", 32'(ccwait), 32'h2);
        check("fill0 snoop2 dwait", 32'(dwait), 32'h3);
        tick(); settle();
        check("fill0 busy ramREN", 32'(ramREN), 32'h1);
        check("fill0 busy dwait", 32'(dwait), 32'h3);
        check("fill0 busy ccwait", 32'(ccwait), 32'h0);
        ramstate = RamAccess; ramload = 32'hA0; settle();
        check("fill0 w0 dwait", 32'(dwait), 32'h2);
        check("fill0 w0 dload", dload[0], 32'hA0);
        check("fill0 w0 ramaddr", ramaddr, 32'h100);
        tick();
        daddr[0] = 32'h104; ramload = 32'hA4; settle();
        check("fill0 w1 dwait", 32'(dwait), 32'h2);
        check("fill0 w1 dload", dload[0], 32'hA4);
        check("fill0 w1 ramaddr", ramaddr, 32'h104);
        dREN[0] = 1'b0;
        tick(); settle();
        check_idle_outputs("fill0_done");

        // Cache 1 fill supplied by cache 0 holding the line MODIFIED
        dREN[1] = 1'b1; daddr[1] = 32'h200;
        tick(); settle();
        check("c2c snoop1 ccwait", 32'(ccwait), 32'h1);
        check("c2c snoop1 addr", ccsnoopaddr[0], 32'h200);
        dWEN[0] = 1'b1; cctrans[0] = 1'b1; dstore[0] = 32'h11;
        tick(); settle();
        check("c2c snoop2 ccwait", 32'(ccwait), 32'h1);
        check("c2c snoop2 dwait", 32'(dwait), 32'h3);
        tick(); settle();
        check("c2c w0 dwait", 32'(dwait), 32'h1);
        check("c2c w0 dload", dload[1], 32'h11);
        check("c2c w0 ramWEN", 32'({ramREN, ramWEN}), 32'h1);
        check("c2c w0 ramaddr", ramaddr, 32'h200);
        check("c2c w0 ramstore", ramstore, 32'h11);
        tick();
        daddr[1] = 32'h204; dstore[0] = 32'h22; settle();
        check("c2c w1 dload", dload[1], 32'h22);
        check("c2c w1 ramaddr", ramaddr, 32'h204);
        check("c2c w1 ramstore", ramstore, 32'h22);
        check("c2c w1 ccwait", 32'(ccwait), 32'h1);
        check("c2c w1 snoopaddr", ccsnoopaddr[0], 32'h204);
        dREN[1] = 1'b0; dWEN[0] = 1'b0; cctrans[0] = 1'b0;
        tick(); settle();
        check_idle_outputs("c2c_done");

        // Cache 0 upgrade of a SHARED line
        ccwrite[0] = 1'b1; daddr[0] = 32'h300;
        tick(); settle();
        check("inv snoop1 ccwait", 32'(ccwait), 32'h2);
        check("inv snoop1 ccinv", 32'(ccinv), 32'h2);
        check("inv snoop1 addr", ccsnoopaddr[1], 32'h300);
        tick(); settle();
        check("inv snoop2 ccinv", 32'(ccinv), 32'h2);
        check("inv snoop2 dwait", 32'(dwait), 32'h3);
        tick(); settle();
        check("inv cyc ccwait", 32'(ccwait), 32'h2);
        check("inv cyc ccinv", 32'(ccinv), 32'h2);
        check("inv cyc dwait", 32'(dwait), 32'h2);
        check("inv cyc ram", 32'({ramREN, ramWEN}), 32'h0);
        ccwrite[0] = 1'b0;
        tick(); settle();
        check_idle_outputs("inv_done");

        // Fresh reset restores the round-robin pointer; then both caches fill
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        dREN = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500;
        ramstate = RamAccess; ramload = 32'h1;
        tick(); settle();
        check("rr1 ccwait", 32'(ccwait), 32'h2);
        check("rr1 snoopaddr", ccsnoopaddr[1], 32'h400);
        tick(); tick(); settle();
        check("rr1 w0 dwait", 32'(dwait), 32'h2);
        check("rr1 w0 dload", dload[0], 32'h1);
        tick();
        daddr[0] = 32'h404; ramload = 32'h2; settle();
        check("rr1 w1 dload", dload[0], 32'h2);
        daddr[0] = 32'h600;
        tick(); settle();
        check_idle_outputs("rr1_done");
        tick(); settle();
        check("rr2 ccwait", 32'(ccwait), 32'h1);
        check("rr2 snoopaddr", ccsnoopaddr[0], 32'h500);
        tick(); tick(); settle();
        check("rr2 w0 dwait", 32'(dwait), 32'h1);
        check("rr2 w0 ramaddr", ramaddr, 32'h500);

        // Asynchronous reset mid-RAMRD
        ramstate = RamBusy;
        tick(); settle();
        check("rd busy ramREN", 32'(ramREN), 32'h1);
        nRST = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset dload", dload[1], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Bus-side coherence controller serving two snooping MESI data caches, one shared instruction-fetch port and a single-ported RAM. It arbitrates block fills, writebacks and upgrade-invalidations. It drives the snoop signals (ccwait/ccinv/ccsnoopaddr) into the non-requesting cache and routes either cache-to-cache data or RAM data back to the requester. It sits between the per-core caches and the RAM model, forming the responder end of the cache coherence interface.

## Interface
- CPUS, 2, number of data caches; only 2 is supported.
- BLKWORDS, 2, words per block; the fill and snoop sequence is 2 words.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- dREN  in  [1:0]  per-cache read request (block fill word).
- dWEN  in  [1:0]  per-cache write request (writeback), or snoop-supply flag while that cache is being snooped.
- daddr  in  [1:0][31:0]  per-cache word address.
- dstore  in  [1:0][31:0]  per-cache write or supply data.
- ccwrite  in  [1:0]  request is a write to a SHARED line (needs invalidation).
- cctrans  in  [1:0]  while supplying: line was MODIFIED (RAM must also be updated).
- dwait  out  [1:0]  per-cache stall; 0 for one cycle completes the current word.
- dload  out  [1:0][31:0]  per-cache read data, valid when dwait low.
- ccwait  out  [1:0]  snoop in progress for that cache.
- ccinv  out  [1:0]  snoop is an invalidate.
- ccsnoopaddr  out  [1:0][31:0]  address being snooped.
- iREN  in  1  instruction fetch request.
- iaddr  in  32  fetch address.
- iwait  out  1  fetch stall.
- iload  out  32  fetch data.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR; only ACCESS completes an access.

## Operation
- States: IDLE, IFETCH, WB, SNOOP, RAMRD, C2C, INV.
- Registers: req (requester index r; s = ~r), rr (round-robin pointer), wcnt (word 0/1), scnt (snoop cycle 0/1), hitflag.
- IDLE arbitration, in priority order; cache x is eligible only if ccwait[x]=0:
  - Coherent requests (dREN[x], or ccwrite[x] with dREN[x]=0), round-robin starting at ~rr → SNOOP. Latch r; wcnt=0; scnt=0.
  - Writeback dWEN[x] with dREN[x]=0, lower index first → WB.
  - iREN → IFETCH.
  - dREN and dWEN both high from one cache: dREN wins; the writeback is taken later as a separate transaction.
- IFETCH: ramREN=1, ramaddr=iaddr. On ACCESS: iwait=0, iload=ramload → IDLE.
- WB: ramWEN=1, ramaddr/ramstore from cache r. On ACCESS: dwait[r]=0 → IDLE.
- SNOOP: ccwait[s]=1, ccsnoopaddr[s]=daddr[r], ccinv[s]=ccwrite[r]&~dREN[r]. Held exactly 2 cycles. In the second cycle, sample dWEN[s] into hitflag. Next state:
  - ccinv → INV.
  - hitflag → C2C.
  - otherwise → RAMRD; ccwait[s] drops.
- INV: ccwait[s]=1, ccinv[s]=1 for one cycle, dwait[r]=0 → IDLE. rr=r.
- RAMRD: ramREN=1, ramaddr=daddr[r]. On ACCESS: dwait[r]=0, dload[r]=ramload, wcnt++. After word 1 → IDLE, rr=r.
- C2C: ccwait[s]=1, ccsnoopaddr[s]=daddr[r] (tracks the second-word address), dload[r]=dstore[s].
  - cctrans[s]=0: dwait[r]=0 each cycle a word is taken.
  - cctrans[s]=1: ramWEN=1, ramaddr=daddr[r], ramstore=dstore[s]; dwait[r]=0 only on ACCESS.
  - After word 1: ccwait[s] drops → IDLE, rr=r.
- Outputs are combinational from state, registers and inputs.
- Unselected defaults: dwait=1, dload=0, iwait=1, iload=0, ccwait/ccinv=0, ccsnoopaddr=0, RAM strobes 0, ramaddr/ramstore=0.
- ERROR or BUSY on ramstate: stay in state, keep strobes asserted.

## Timing
- Reset (async, nRST low): state IDLE, rr=1 (cache 0 wins the first tie), wcnt=scnt=hitflag=0. Outputs: dwait=2'b11, iwait=1, all other outputs 0.
- Reset mid-transaction aborts immediately. No RAM strobe is asserted in the cycle after nRST rises.
- Snoop latency: 2 cycles from entering SNOOP to the first data-path cycle.
- Best-case fill latency, RAM answering ACCESS in the first cycle: 2 snoop cycles + 2 data cycles = 4 cycles.
- Only one dwait bit is ever low in a cycle; iwait low never coincides with a dwait low.
- No new transaction starts in the cycle a transaction completes. IDLE always lasts at least one cycle.
- Both caches requesting in the same cycle: grant ~rr. The loser keeps its request and is served next; no starvation.
- The requester must not change daddr[r] until its dwait drops. The second word address is daddr[r] with bit 2 toggled.

## Test plan
- Reset, then IDLE with all requests low -> dwait=2'b11, iwait=1, ccwait=0, RAM strobes 0.
- iREN=1, iaddr=0x40, ramstate=ACCESS with ramload=0xDEADBEEF -> IFETCH one cycle, iwait=0, iload=0xDEADBEEF, then IDLE.
- Cache 0 dREN, daddr=0x100; cache 1 dWEN=0 during snoop -> ccwait[1]=1 with ccsnoopaddr[1]=0x100 for 2 cycles. Then RAM reads 0x100 and 0x104; dwait[0] low twice, carrying ramload values.
- Cache 1 fill 0x200; cache 0 supplies with dWEN[0]=1, cctrans[0]=1, dstore=0x11/0x22 -> dload[1]=0x11 then 0x22. ramWEN writes 0x200=0x11 and 0x204=0x22; ccwait[0] drops after the second word.
- Cache 0 ccwrite=1, dREN=0, daddr=0x300 -> ccwait[1]=ccinv[1]=1 for the snoop and INV cycles (3 cycles total), then dwait[0]=0 once, no RAM access.
- Both caches raise dREN in the same cycle, twice in a row -> first grant to cache 0, next to cache 1. Then assert nRST low mid-RAMRD -> all outputs return to reset values asynchronously.
